// File: rtl/iram_loader.sv
// iram_loader: UART (8N1) program loader for the instruction RAM.
// Receives a framed packet (A5, N, N data bytes, 8-bit sum), writes the
// data bytes to IRAM from address 0 and releases cpu_hold once the
// checksum matches.
module iram_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int MAX_LEN      = 121
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic       we,
   output logic [7:0] waddr,
   output logic [7:0] wdata,
   output logic       cpu_hold,
   output logic       done,
   output logic       error
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]    MAX_L     = 8'(MAX_LEN);
   localparam logic [7:0]    HDR_BYTE  = 8'hA5;

   localparam logic [1:0] B_IDLE  = 2'd0;
   localparam logic [1:0] B_START = 2'd1;
   localparam logic [1:0] B_DATA  = 2'd2;
   localparam logic [1:0] B_STOP  = 2'd3;

   localparam logic [2:0] P_HDR  = 3'd0;
   localparam logic [2:0] P_LEN  = 3'd1;
   localparam logic [2:0] P_DATA = 3'd2;
   localparam logic [2:0] P_CSUM = 3'd3;
   localparam logic [2:0] P_DONE = 3'd4;

   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic [1:0]    b_state_q, b_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          bv_q, bv_d;
   logic          frame_err;

   logic [2:0]    p_state_q, p_state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    idx_q, idx_d;
   logic [7:0]    sum_q, sum_d;
   logic          we_q, we_d;
   logic [7:0]    waddr_q, waddr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   // Two-flop synchronizer plus one delayed copy for falling-edge detect
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Bit engine: start detect, mid-bit sampling, stop check
   always_comb begin
      b_state_d = b_state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      bv_d      = 1'b0;
      frame_err = 1'b0;
      case (b_state_q)
         B_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               b_state_d = B_START;
               cnt_d     = '0;
            end
         end
         B_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_d     = '0;
               b_state_d = rx_s2_q ? B_IDLE : B_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         B_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s2_q, shift_q[7:1]};
               if (bit_q == 3'd7) b_state_d = B_STOP;
               else               bit_d     = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         B_STOP: begin
            if (cnt_q == BIT_LAST) begin
               b_state_d = B_IDLE;
               if (rx_s2_q) bv_d      = 1'b1;
               else         frame_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: b_state_d = B_IDLE;
      endcase
   end

   // Bit engine registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         b_state_q <= B_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         bv_q      <= 1'b0;
      end else begin
         b_state_q <= b_state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         bv_q      <= bv_d;
      end
   end

   // Packet FSM: header/length/data/checksum handling and IRAM writes
   always_comb begin
      p_state_d = p_state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;
      if (frame_err) begin
         err_d     = 1'b1;
         p_state_d = P_HDR;
      end else if (bv_q) begin
         case (p_state_q)
            P_HDR, P_DONE: begin
               if (shift_q == HDR_BYTE) begin
                  p_state_d = P_LEN;
                  err_d     = 1'b0;
                  sum_d     = '0;
                  idx_d     = '0;
                  hold_d    = 1'b1;
                  done_d    = 1'b0;
               end
            end
            P_LEN: begin
               if (shift_q == 8'd0 || shift_q > MAX_L) begin
                  err_d     = 1'b1;
                  p_state_d = P_HDR;
               end else begin
                  len_d     = shift_q;
                  p_state_d = P_DATA;
               end
            end
            P_DATA: begin
               we_d    = 1'b1;
               waddr_d = idx_q;
               wdata_d = shift_q;
               sum_d   = sum_q + shift_q;
               if (idx_q == len_q - 1'b1) p_state_d = P_CSUM;
               else                       idx_d     = idx_q + 1'b1;
            end
            P_CSUM: begin
               if (shift_q == sum_q) begin
                  p_state_d = P_DONE;
                  done_d    = 1'b1;
                  hold_d    = 1'b0;
               end else begin
                  err_d     = 1'b1;
                  p_state_d = P_HDR;
               end
            end
            default: p_state_d = P_HDR;
         endcase
      end
   end

   // Packet FSM and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         p_state_q <= P_HDR;
         len_q     <= '0;
         idx_q     <= '0;
         sum_q     <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         hold_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         p_state_q <= p_state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign error    = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader: drives UART frames into iram_loader and checks writes and
// status flags against a byte-level packet model.
module tb_iram_loader;

   localparam int CPB  = 8;
   localparam int MAXL = 121;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx = 1'b1;
   logic       we;
   logic [7:0] waddr, wdata;
   logic       cpu_hold, done, error;

   iram_loader #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL)) dut (
      .clk(clk), .rstn(rstn), .rx(rx), .we(we), .waddr(waddr),
      .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // observed writes, sampled mid-cycle
   logic [15:0] obs_q[$];
   always @(negedge clk) if (rstn === 1'b1 && we === 1'b1) obs_q.push_back({waddr, wdata});

   // reference model
   typedef enum {M_HDR, M_LEN, M_DATA, M_CSUM, M_DONE} mph_t;
   mph_t m_ph;
   int   m_len, m_cnt, m_sum;
   bit   m_done, m_hold, m_err;
   logic [15:0] exp_q[$];

   function automatic void m_reset();
      m_ph = M_HDR; m_done = 0; m_hold = 1; m_err = 0;
      m_len = 0; m_cnt = 0; m_sum = 0;
      exp_q.delete();
   endfunction

   function automatic void m_byte(input logic [7:0] b);
      case (m_ph)
         M_HDR, M_DONE: if (b == 8'hA5) begin
            m_ph = M_LEN; m_err = 0; m_sum = 0; m_cnt = 0; m_hold = 1; m_done = 0;
         end
         M_LEN: if (b == 0 || int'(b) > MAXL) begin
            m_err = 1; m_ph = M_HDR;
         end else begin
            m_len = b; m_ph = M_DATA;
         end
         M_DATA: begin
            exp_q.push_back({8'(m_cnt), b});
            m_sum = (m_sum + b) % 256;
            m_cnt++;
            if (m_cnt == m_len) m_ph = M_CSUM;
         end
         M_CSUM: if (int'(b) == m_sum) begin
            m_ph = M_DONE; m_done = 1; m_hold = 0;
         end else begin
            m_err = 1; m_ph = M_HDR;
         end
         default: m_ph = M_HDR;
      endcase
   endfunction

   task automatic check_flags(input string tag);
      chk({tag, ".done"}, done, m_done);
      chk({tag, ".hold"}, cpu_hold, m_hold);
      chk({tag, ".err"}, error, m_err);
   endtask

   task automatic check_writes(input string tag);
      int n;
      chk({tag, ".nwr"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, ".wr"}, obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   // One 8N1 frame; entered and left just after a falling clock edge.
   // Flags are checked one cycle before and exactly on the cycle the byte
   // should take effect.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop, input string tag);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = !bad_stop;
      repeat (CPB - 1) @(negedge clk);
      #1;
      if (bad_stop) begin
         m_err = 1; m_ph = M_HDR;
      end
      check_flags({tag, ".pre"});
      @(negedge clk);
      rx = 1'b1;
      if (!bad_stop) m_byte(b);
      #1;
      check_flags(tag);
      check_writes(tag);
   endtask

   logic [7:0] pkt[$];

   task automatic send_pkt(input string tag);
      foreach (pkt[i]) send_byte(pkt[i], 1'b0, tag);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".we"}, we, 1'b0);
      chk({tag, ".waddr"}, waddr, 8'h00);
      chk({tag, ".wdata"}, wdata, 8'h00);
      check_flags(tag);
   endtask

   initial begin
      int sum, len;
      m_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check_reset_vals("reset");
      idle(200);
      check_flags("idle");
      check_writes("idle");

      pkt = {8'hA5, 8'h03, 8'h07, 8'h08, 8'h03, 8'h12};
      send_pkt("valid");
      chk("valid.done_set", done, 1'b1);

      pkt = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      send_pkt("badsum");
      chk("badsum.err_set", error, 1'b1);
      pkt = {8'hA5, 8'h01, 8'h05, 8'h05};
      send_pkt("recover");

      pkt = {8'h3C, 8'hA5, 8'h00};
      send_pkt("len0");
      idle(10);
      pkt = {8'hA5, 8'h7A};
      send_pkt("len122");
      chk("len122.err_set", error, 1'b1);

      pkt = {8'hA5, 8'h02, 8'h11};
      send_pkt("frame");
      send_byte(8'h22, 1'b1, "frame.bad");
      idle(20);
      pkt = {8'h33};
      send_pkt("frame.after");

      pkt = {8'hA5, 8'h01, 8'h05, 8'h05};
      send_pkt("pre_glitch");
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      idle(60);
      check_flags("glitch");
      check_writes("glitch");

      // reset during the third data bit of the second data byte
      pkt = {8'hA5, 8'h02, 8'h44};
      send_pkt("midrst");
      rx = 1'b0;
      repeat (CPB * 3 + CPB / 2) @(negedge clk);
      rx = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      rx = 1'b1;
      m_reset();
      obs_q.delete();
      #1;
      check_reset_vals("midrst.rst");
      idle(30);
      pkt = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h65};
      send_pkt("afterrst");

      pkt = {8'hA5, 8'h01, 8'hFF, 8'hFF};
      send_pkt("reload");

      // maximum length packet
      pkt = {8'hA5, 8'(MAXL)};
      sum = 0;
      for (int i = 0; i < MAXL; i++) begin
         pkt.push_back(8'($urandom));
         sum += pkt[pkt.size() - 1];
      end
      pkt.push_back(8'(sum % 256));
      send_pkt("maxlen");
      chk("maxlen.done_set", done, 1'b1);

      // randomized packets with junk, bad checksums and bad lengths
      for (int p = 0; p < 12; p++) begin
         pkt.delete();
         if ($urandom_range(0, 3) == 0) pkt.push_back(8'($urandom));
         len = $urandom_range(1, 12);
         if ($urandom_range(0, 7) == 0) len = 0;
         pkt.push_back(8'hA5);
         pkt.push_back(8'(len));
         sum = 0;
         for (int i = 0; i < len; i++) begin
            pkt.push_back(8'($urandom));
            sum += pkt[pkt.size() - 1];
         end
         if (len != 0) pkt.push_back(8'((sum + (($urandom_range(0, 3) == 0) ? 1 : 0)) % 256));
         send_pkt("rand");
         idle($urandom_range(0, 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
